// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew data hazards,
// mult/div busy sequencing, pipeline register enables and a stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [3:0]  D_rs_Tuse,
    input  logic [3:0]  D_rt_Tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_GRF_A3,
    input  logic        E_GRF_write,
    input  logic [3:0]  E_Tnew,
    input  logic [4:0]  M_GRF_A3,
    input  logic        M_GRF_write,
    input  logic [3:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_op,
    output logic        PC_EN,
    output logic        F_D_REG_EN,
    output logic        D_E_REG_EN,
    output logic        D_E_REG_flush,
    output logic        E_M_REG_EN,
    output logic        M_W_REG_EN,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] r_md_cnt;
    logic [31:0]      r_stall_cnt;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_md;

    // A source stalls when its producer in E or M delivers later than D consumes it.
    // $0 is hard-wired zero, so it never carries a dependency.
    always_comb begin
        w_stall_rs = (D_rs_addr != 5'd0) &&
                     ((E_GRF_write && (E_GRF_A3 == D_rs_addr) && (E_Tnew > D_rs_Tuse)) ||
                      (M_GRF_write && (M_GRF_A3 == D_rs_addr) && (M_Tnew > D_rs_Tuse)));
        w_stall_rt = (D_rt_addr != 5'd0) &&
                     ((E_GRF_write && (E_GRF_A3 == D_rt_addr) && (E_Tnew > D_rt_Tuse)) ||
                      (M_GRF_write && (M_GRF_A3 == D_rt_addr) && (M_Tnew > D_rt_Tuse)));
        w_stall_md = D_is_md && (md_busy || E_md_start);
    end

    assign md_busy   = (r_md_cnt != '0);
    assign stall     = w_stall_rs | w_stall_rt | w_stall_md;
    assign stall_cnt = r_stall_cnt;

    // On a stall D/E stays enabled so the flush actually writes the bubble.
    assign PC_EN         = ~stall;
    assign F_D_REG_EN    = ~stall;
    assign D_E_REG_EN    = 1'b1;
    assign D_E_REG_flush = stall;
    assign E_M_REG_EN    = 1'b1;
    assign M_W_REG_EN    = 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (E_md_start) begin
            r_md_cnt <= E_md_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: hazard vector table, hand-written
// mult/div and reset sequences, and random traffic against a cycle-indexed model.
module tb_hazard_stall_ctrl;

    typedef struct {
        logic [4:0] rs, rt;
        logic [3:0] rs_tuse, rt_tuse;
        logic       is_md;
        logic [4:0] e_a3;
        logic       e_w;
        logic [3:0] e_tnew;
        logic [4:0] m_a3;
        logic       m_w;
        logic [3:0] m_tnew;
        logic       start, op;
    } in_t;

    typedef struct {
        in_t  in;
        logic exp_stall;
    } vec_t;

    logic        clk, reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_GRF_A3, M_GRF_A3;
    logic [3:0]  D_rs_Tuse, D_rt_Tuse, E_Tnew, M_Tnew;
    logic        D_is_md, E_GRF_write, M_GRF_write, E_md_start, E_md_op;
    logic        PC_EN, F_D_REG_EN, D_E_REG_EN, D_E_REG_flush, E_M_REG_EN, M_W_REG_EN;
    logic        stall, md_busy;
    logic [31:0] stall_cnt;

    int     errors = 0;
    int     checks = 0;
    in_t    cur;
    int     cyc    = 0;
    int     md_end = -1;   // last cycle index during which the unit reads busy
    longint exp_cnt = 0;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse), .D_is_md(D_is_md),
        .E_GRF_A3(E_GRF_A3), .E_GRF_write(E_GRF_write), .E_Tnew(E_Tnew),
        .M_GRF_A3(M_GRF_A3), .M_GRF_write(M_GRF_write), .M_Tnew(M_Tnew),
        .E_md_start(E_md_start), .E_md_op(E_md_op),
        .PC_EN(PC_EN), .F_D_REG_EN(F_D_REG_EN), .D_E_REG_EN(D_E_REG_EN),
        .D_E_REG_flush(D_E_REG_flush), .E_M_REG_EN(E_M_REG_EN), .M_W_REG_EN(M_W_REG_EN),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs, input logic [3:0] rs_tuse,
                               input logic [4:0] rt, input logic [3:0] rt_tuse,
                               input logic [4:0] e_a3, input logic e_w, input logic [3:0] e_tnew,
                               input logic [4:0] m_a3, input logic m_w, input logic [3:0] m_tnew);
        in_t v;
        v.rs = rs; v.rs_tuse = rs_tuse; v.rt = rt; v.rt_tuse = rt_tuse;
        v.e_a3 = e_a3; v.e_w = e_w; v.e_tnew = e_tnew;
        v.m_a3 = m_a3; v.m_w = m_w; v.m_tnew = m_tnew;
        v.is_md = 1'b0; v.start = 1'b0; v.op = 1'b0;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(5'd0, 4'd15, 5'd0, 4'd15, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 4'd0);
    endfunction

    // Reference: a consumer stalls if any in-flight writer of its register is later than its need.
    function automatic bit src_late(input logic [4:0] addr, input logic [3:0] tuse);
        int need;
        bit late;
        need = int'(tuse);
        late = 1'b0;
        if (addr != 0) begin
            if (cur.e_w && cur.e_a3 == addr && int'(cur.e_tnew) > need) late = 1'b1;
            if (cur.m_w && cur.m_a3 == addr && int'(cur.m_tnew) > need) late = 1'b1;
        end
        return late;
    endfunction

    function automatic bit model_busy();
        return cyc <= md_end;
    endfunction

    function automatic bit model_stall();
        return src_late(cur.rs, cur.rs_tuse) || src_late(cur.rt, cur.rt_tuse) ||
               (cur.is_md && (model_busy() || cur.start));
    endfunction

    task automatic drive(input in_t v);
        cur = v;
        D_rs_addr = v.rs;   D_rs_Tuse = v.rs_tuse;
        D_rt_addr = v.rt;   D_rt_Tuse = v.rt_tuse;
        D_is_md   = v.is_md;
        E_GRF_A3  = v.e_a3; E_GRF_write = v.e_w; E_Tnew = v.e_tnew;
        M_GRF_A3  = v.m_a3; M_GRF_write = v.m_w; M_Tnew = v.m_tnew;
        E_md_start = v.start; E_md_op = v.op;
    endtask

    task automatic check_cycle(input string name);
        bit s, b;
        #2;
        s = model_stall();
        b = model_busy();
        check({name, ".ctrl"},
              {24'd0, stall, PC_EN, F_D_REG_EN, D_E_REG_EN, D_E_REG_flush, E_M_REG_EN, M_W_REG_EN, md_busy},
              {24'd0, s, !s, !s, 1'b1, s, 1'b1, 1'b1, b});
        check({name, ".cnt"}, stall_cnt, exp_cnt[31:0]);
    endtask

    task automatic tick();
        bit s;
        s = model_stall();
        @(posedge clk);
        if (s && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
        if (cur.start) md_end = cyc + (cur.op ? 10 : 5);
        cyc++;
        #1;
    endtask

    function automatic logic [3:0] rnd_tuse();
        int t;
        t = $urandom_range(0, 4);
        return (t == 4) ? 4'd15 : 4'(t);
    endfunction

    initial begin
        vec_t vecs[$];
        in_t  v;

        // Reset state while reset is held low
        reset = 1'b0;
        drive(idle());
        check_cycle("reset");
        check("reset.busy", {31'd0, md_busy}, 32'd0);
        #1 reset = 1'b1;
        tick();

        // Hazard table: {rs,Tuse, rt,Tuse, E a3/w/Tnew, M a3/w/Tnew} -> stall
        vecs.push_back('{mk(5'd2, 4'd1, 5'd1, 4'd1, 5'd2, 1'b1, 4'd2, 5'd0, 1'b0, 4'd0), 1'b1}); // load-use
        vecs.push_back('{mk(5'd2, 4'd1, 5'd1, 4'd1, 5'd0, 1'b0, 4'd0, 5'd2, 1'b1, 4'd1), 1'b0}); // lw now in M
        vecs.push_back('{mk(5'd4, 4'd0, 5'd0, 4'd15, 5'd0, 1'b0, 4'd0, 5'd4, 1'b1, 4'd1), 1'b1}); // branch vs M lw
        vecs.push_back('{mk(5'd4, 4'd0, 5'd0, 4'd15, 5'd0, 1'b0, 4'd0, 5'd4, 1'b1, 4'd0), 1'b0}); // M ready
        vecs.push_back('{mk(5'd0, 4'd0, 5'd0, 4'd15, 5'd0, 1'b1, 4'd2, 5'd0, 1'b1, 4'd3), 1'b0}); // $0 immune
        vecs.push_back('{mk(5'd0, 4'd15, 5'd7, 4'd0, 5'd7, 1'b1, 4'd1, 5'd0, 1'b0, 4'd0), 1'b1}); // rt vs E
        vecs.push_back('{mk(5'd5, 4'd0, 5'd0, 4'd15, 5'd5, 1'b0, 4'd3, 5'd0, 1'b0, 4'd0), 1'b0}); // no write
        vecs.push_back('{mk(5'd5, 4'd15, 5'd5, 4'd15, 5'd5, 1'b1, 4'd3, 5'd5, 1'b1, 4'd3), 1'b0}); // Tuse=15
        vecs.push_back('{mk(5'd5, 4'd0, 5'd0, 4'd15, 5'd6, 1'b1, 4'd3, 5'd0, 1'b0, 4'd0), 1'b0}); // other reg
        vecs.push_back('{mk(5'd0, 4'd15, 5'd9, 4'd1, 5'd0, 1'b0, 4'd0, 5'd9, 1'b1, 4'd2), 1'b1}); // rt vs M
        vecs.push_back('{mk(5'd3, 4'd2, 5'd0, 4'd15, 5'd3, 1'b1, 4'd2, 5'd0, 1'b0, 4'd0), 1'b0}); // Tnew==Tuse
        vecs.push_back('{mk(5'd3, 4'd1, 5'd3, 4'd3, 5'd3, 1'b1, 4'd2, 5'd3, 1'b1, 4'd1), 1'b1}); // rs late, rt ok
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            #2;
            check($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            check_cycle($sformatf("vec%0d", i));
            tick();
        end
        drive(idle());
        check_cycle("after_table");
        check("after_table.cnt", stall_cnt, 32'd5);
        tick();

        // Div: mflo in D stalls at the start cycle and for the 10 busy cycles
        v = idle(); v.is_md = 1'b1; v.start = 1'b1; v.op = 1'b1;
        drive(v);
        check_cycle("div_t");
        check("div_t.stall", {31'd0, stall}, 32'd1);
        tick();
        v.start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            drive(v);
            check_cycle($sformatf("div_t+%0d", k));
            check($sformatf("div_t+%0d.busy", k), {31'd0, md_busy}, {31'd0, k <= 10});
            check($sformatf("div_t+%0d.stall", k), {31'd0, stall}, {31'd0, k <= 10});
            tick();
        end

        // Mult, then div restarted at busy cycle 3
        v = idle(); v.start = 1'b1; v.op = 1'b0;
        drive(v); check_cycle("rst_mult"); tick();
        for (int k = 1; k <= 14; k++) begin
            v.start = (k == 3); v.op = 1'b1;
            drive(v);
            check_cycle($sformatf("restart+%0d", k));
            check($sformatf("restart+%0d.busy", k), {31'd0, md_busy}, {31'd0, k <= 13});
            tick();
        end

        // Mult restarted on its last busy cycle: no gap
        v = idle(); v.start = 1'b1; v.op = 1'b0;
        drive(v); check_cycle("b2b_mult"); tick();
        for (int k = 1; k <= 11; k++) begin
            v.start = (k == 5);
            drive(v);
            check_cycle($sformatf("b2b+%0d", k));
            check($sformatf("b2b+%0d.busy", k), {31'd0, md_busy}, {31'd0, k <= 10});
            tick();
        end

        // Asynchronous reset mid-countdown, away from any clock edge
        v = idle(); v.is_md = 1'b1; v.start = 1'b1; v.op = 1'b1;
        drive(v); check_cycle("ar_start"); tick();
        v.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(v); check_cycle($sformatf("ar_busy%0d", k)); tick();
        end
        #2 reset = 1'b0;
        #1;
        md_end  = -1;
        exp_cnt = 0;
        check("async_rst.busy", {31'd0, md_busy}, 32'd0);
        check("async_rst.cnt", stall_cnt, 32'd0);
        check("async_rst.stall", {31'd0, stall}, 32'd0);
        #2 reset = 1'b1;
        tick();
        drive(v);
        check_cycle("post_rst");
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            v.rs = 5'($urandom_range(0, 3));  v.rs_tuse = rnd_tuse();
            v.rt = 5'($urandom_range(0, 3));  v.rt_tuse = rnd_tuse();
            v.e_a3 = 5'($urandom_range(0, 3)); v.e_w = 1'($urandom_range(0, 1));
            v.e_tnew = 4'($urandom_range(0, 3));
            v.m_a3 = 5'($urandom_range(0, 3)); v.m_w = 1'($urandom_range(0, 1));
            v.m_tnew = 4'($urandom_range(0, 3));
            v.is_md = ($urandom_range(0, 2) == 0);
            v.start = ($urandom_range(0, 7) == 0);
            v.op    = 1'($urandom_range(0, 1));
            drive(v);
            check_cycle($sformatf("rnd%0d", n));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
